// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock: FSM state encoding, idle key code, timeout default.
// Also used by the key-entry register and the LCD display stage.
package alarm_clock_pkg;

  localparam logic [3:0]  NOKEY             = 4'd10;
  localparam int unsigned TIMEOUT_S_DEFAULT = 10;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  // The timeout only runs while a key entry is open.
  function automatic logic is_entry_state(input state_t s);
    return (s == KEY_WAITED) || (s == KEY_ENTRY);
  endfunction

endpackage

// File: rtl/alarm_clock_if.sv
// Keypad/button inputs and display/strobe outputs of the alarm clock controller.
// master = surrounding clock datapath, slave = control FSM.
interface alarm_clock_if;
  import alarm_clock_pkg::*;

  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       show_a;
  logic       show_new_time;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  show_a, show_new_time, shift, load_new_a, load_new_c
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output show_a, show_new_time, shift, load_new_a, load_new_c
  );

endinterface

// File: rtl/alarm_clock_timeout_cnt.sv
// Saturating seconds counter for the key-entry timeout; time_out is combinational from the count.
// clear has priority over counting; counting stops at TIMEOUT_S.
module alarm_clock_timeout_cnt
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic time_out
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT_S);

  logic [3:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable && one_second && (count != LIMIT)) begin
      count <= count + 4'd1;
    end
  end

  assign time_out = (count == LIMIT);

endmodule

// File: rtl/alarm_clock_fsm.sv
// Alarm clock control FSM: Moore display selects and one-cycle load/shift strobes, 1-clock latency.
// Optional macro ALARM_CLOCK_KEY_SYNC_EN adds 2-flop synchronizers on key and buttons.
module alarm_clock_fsm
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  alarm_clock_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] key_s;
  logic       alarm_s;
  logic       time_s;
  logic       time_out;
  logic       key_pressed;

`ifdef ALARM_CLOCK_KEY_SYNC_EN
  logic [3:0] key_m;
  logic       alarm_m;
  logic       time_m;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_m   <= NOKEY;
      key_s   <= NOKEY;
      alarm_m <= 1'b0;
      alarm_s <= 1'b0;
      time_m  <= 1'b0;
      time_s  <= 1'b0;
    end else begin
      key_m   <= bus.key;
      key_s   <= key_m;
      alarm_m <= bus.alarm_button;
      alarm_s <= alarm_m;
      time_m  <= bus.time_button;
      time_s  <= time_m;
    end
  end
`else
  assign key_s   = bus.key;
  assign alarm_s = bus.alarm_button;
  assign time_s  = bus.time_button;
`endif

  assign key_pressed = (key_s != NOKEY);

  alarm_clock_timeout_cnt #(
    .TIMEOUT_S (TIMEOUT_S)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear      (!is_entry_state(state)),
    .enable     (is_entry_state(state)),
    .one_second (bus.one_second),
    .time_out   (time_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    bus.show_a        = 1'b0;
    bus.show_new_time = 1'b0;
    bus.shift         = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (alarm_s)          state_nxt = SHOW_ALARM;
        else if (key_pressed) state_nxt = KEY_STORED;
      end
      KEY_STORED: begin
        bus.shift = 1'b1;
        state_nxt = KEY_WAITED;
      end
      KEY_WAITED: begin
        // Timeout beats a simultaneous release so a stuck entry always closes.
        bus.show_new_time = 1'b1;
        if (time_out)          state_nxt = SHOW_TIME;
        else if (!key_pressed) state_nxt = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        bus.show_new_time = 1'b1;
        if (alarm_s)          state_nxt = SET_ALARM_TIME;
        else if (time_s)      state_nxt = SET_CURRENT_TIME;
        else if (key_pressed) state_nxt = KEY_STORED;
        else if (time_out)    state_nxt = SHOW_TIME;
      end
      SHOW_ALARM: begin
        bus.show_a = 1'b1;
        if (!alarm_s) state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME: begin
        bus.load_new_a = 1'b1;
        state_nxt      = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        bus.load_new_c = 1'b1;
        state_nxt      = SHOW_TIME;
      end
      default: state_nxt = SHOW_TIME;
    endcase
  end

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Directed and random stimulus for alarm_clock_fsm, checked every cycle against a mode-level model.
module tb_alarm_clock_fsm;
  import alarm_clock_pkg::*;

  localparam int TO = 10;
`ifdef ALARM_CLOCK_KEY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset;
  alarm_clock_if bus();

  alarm_clock_fsm #(.TIMEOUT_S(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int shifts, loads_a, loads_c;

  // Model: what the user is doing, plus any one-cycle strobe currently shown.
  typedef enum int {M_IDLE, M_ALARM, M_ENTRY} mode_t;
  typedef enum int {P_NONE, P_SHIFT, P_LOAD_A, P_LOAD_C} pulse_t;
  mode_t      mode;
  pulse_t     pulse;
  bit         releasing;
  int         secs;
  logic [3:0] pk1, pk2;
  logic       pa1, pa2, pt1, pt2;

  function automatic void model_reset();
    mode = M_IDLE; pulse = P_NONE; releasing = 1'b0; secs = 0;
    pk1 = NOKEY; pk2 = NOKEY; pa1 = 1'b0; pa2 = 1'b0; pt1 = 1'b0; pt2 = 1'b0;
  endfunction

  function automatic void model_step(logic [3:0] k_in, logic a_in, logic t_in, logic sec);
    logic [3:0] k;
    logic a, t;
    bit expired;
`ifdef ALARM_CLOCK_KEY_SYNC_EN
    k = pk2; pk2 = pk1; pk1 = k_in;
    a = pa2; pa2 = pa1; pa1 = a_in;
    t = pt2; pt2 = pt1; pt1 = t_in;
`else
    k = k_in; a = a_in; t = t_in;
`endif
    expired = (secs >= TO);
    if (pulse == P_SHIFT) begin
      pulse = P_NONE; releasing = 1'b1; secs = 0;
    end else if (pulse != P_NONE) begin
      pulse = P_NONE;
    end else begin
      case (mode)
        M_IDLE: begin
          if (a) mode = M_ALARM;
          else if (k != NOKEY) begin mode = M_ENTRY; pulse = P_SHIFT; end
        end
        M_ALARM: if (!a) mode = M_IDLE;
        default: begin
          if (sec && secs < TO) secs++;
          if (releasing) begin
            if (expired) mode = M_IDLE;
            else if (k == NOKEY) releasing = 1'b0;
          end
          else if (a)          begin mode = M_IDLE; pulse = P_LOAD_A; end
          else if (t)          begin mode = M_IDLE; pulse = P_LOAD_C; end
          else if (k != NOKEY) pulse = P_SHIFT;
          else if (expired)    mode = M_IDLE;
        end
      endcase
    end
  endfunction

  function automatic logic [4:0] model_out();
    return {mode == M_ALARM, (mode == M_ENTRY) && (pulse == P_NONE),
            pulse == P_SHIFT, pulse == P_LOAD_A, pulse == P_LOAD_C};
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus.show_a, bus.show_new_time, bus.shift, bus.load_new_a, bus.load_new_c};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      if (reset) model_reset();
      else model_step(bus.key, bus.alarm_button, bus.time_button, bus.one_second);
      #1;
      check("outputs", dut_out(), model_out());
      check("exclusive_select", {4'd0, bus.show_a && bus.show_new_time}, 5'd0);
      shifts  += int'(bus.shift);
      loads_a += int'(bus.load_new_a);
      loads_c += int'(bus.load_new_c);
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.key = k; run(2);
    bus.key = NOKEY; run(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.one_second = 1'b0; run(7);
      bus.one_second = 1'b1; run(1);
      bus.one_second = 1'b0;
    end
  endtask

  task automatic clear_counts();
    shifts = 0; loads_a = 0; loads_c = 0;
  endtask

  initial begin
    clear_counts();
    model_reset();
    bus.key = NOKEY; bus.alarm_button = 1'b0; bus.time_button = 1'b0; bus.one_second = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_outputs", dut_out(), 5'd0);
    run(2);
    reset = 1'b0;
    run(20);
    check("idle_outputs", dut_out(), 5'd0);

    // One held key gives exactly one shift; entry display persists after release.
    clear_counts();
    bus.key = 4'd5; run(6);
    bus.key = NOKEY; run(3);
    check_int("held_key_shifts", shifts, 1);
    check("show_new_after_release", {4'd0, bus.show_new_time}, 5'd1);

    clear_counts();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    bus.time_button = 1'b1; run(1);
    bus.time_button = 1'b0; run(4);
    check_int("four_digit_shifts", shifts, 4);
    check_int("set_time_loads", loads_c, 1);
    check("back_to_show_time", {4'd0, bus.show_new_time}, 5'd0);

    // Both buttons together: the alarm load wins.
    clear_counts();
    press(4'd8);
    bus.alarm_button = 1'b1; bus.time_button = 1'b1; run(1);
    bus.alarm_button = 1'b0; bus.time_button = 1'b0; run(4);
    check_int("both_buttons_load_a", loads_a, 1);
    check_int("both_buttons_load_c", loads_c, 0);

    // Timeout: a new digit at tick 9 restarts the count, then 10 idle ticks close entry.
    press(4'd7);
    ticks(9);
    press(4'd3);
    check("entry_alive_after_digit", {4'd0, bus.show_new_time}, 5'd1);
    ticks(9);
    check("entry_alive_tick9", {4'd0, bus.show_new_time}, 5'd1);
    ticks(1);
    run(2);
    check("entry_timed_out", {4'd0, bus.show_new_time}, 5'd0);

    // Timeout while the key is still held.
    bus.key = 4'd9; run(4);
    ticks(10);
    run(1);
    bus.key = NOKEY; run(4);

    bus.alarm_button = 1'b1; run(5);
    check("show_alarm_held", {4'd0, bus.show_a}, 5'd1);
    bus.alarm_button = 1'b0; run(LAT);
    check("show_alarm_released", {4'd0, bus.show_a}, 5'd0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0)
        bus.key = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NOKEY;
      if ($urandom_range(0, 7) == 0) bus.alarm_button = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.time_button = ($urandom_range(0, 3) == 0);
      bus.one_second = ($urandom_range(0, 3) == 0);
      run(1);
    end
    bus.key = NOKEY; bus.alarm_button = 1'b0; bus.time_button = 1'b0; bus.one_second = 1'b0;
    run(6);

    // Asynchronous reset mid-entry, away from a clock edge.
    bus.key = 4'd2; run(4);
    bus.key = NOKEY; run(3);
    check("entry_before_reset", {4'd0, bus.show_new_time}, 5'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", dut_out(), 5'd0);
    run(2);
    #1;
    reset = 1'b0;
    run(5);
    check("after_reset_idle", dut_out(), 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
